// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: operand/flag widths, FU and ALU op encodings,
// the per-entry record, the issue payload and small helpers for wakeup and readiness.
`ifndef RS_SIZE_DEFAULT
`define RS_SIZE_DEFAULT 4
`endif

package reservation_station_pkg;

    localparam int unsigned GPR_SIZE     = 64;
    localparam int unsigned ROB_IDX_SIZE = 4;
    localparam int unsigned AGE_FIELD_W  = 8;  // storage width; AGE_W <= AGE_FIELD_W
    localparam int unsigned RS_SIZE_DFLT = `RS_SIZE_DEFAULT;

    typedef logic [1:0] fu_t;
    localparam fu_t FU_ALU    = 2'd0;
    localparam fu_t FU_LSU    = 2'd1;
    localparam fu_t FU_BRANCH = 2'd2;
    localparam fu_t FU_MUL    = 2'd3;

    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 4'd0;
    localparam alu_op_t ALU_SUB = 4'd1;
    localparam alu_op_t ALU_AND = 4'd2;
    localparam alu_op_t ALU_ORR = 4'd3;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                    busy;
        alu_op_t                 fu_op;
        logic [GPR_SIZE-1:0]     val_a;
        logic                    val_a_valid;
        logic [ROB_IDX_SIZE-1:0] val_a_tag;
        logic [GPR_SIZE-1:0]     val_b;
        logic                    val_b_valid;
        logic [ROB_IDX_SIZE-1:0] val_b_tag;
        nzcv_t                   nzcv;
        logic                    nzcv_valid;
        logic [ROB_IDX_SIZE-1:0] nzcv_tag;
        logic                    set_nzcv;
        logic [ROB_IDX_SIZE-1:0] dst_rob_idx;
        logic [AGE_FIELD_W-1:0]  age;
    } rs_entry_t;

    typedef struct packed {
        alu_op_t                 fu_op;
        logic [GPR_SIZE-1:0]     val_a;
        logic [GPR_SIZE-1:0]     val_b;
        nzcv_t                   nzcv;
        logic                    set_nzcv;
        logic [ROB_IDX_SIZE-1:0] dst_rob_idx;
    } issue_t;

    // Capture a broadcast result into any still-waiting operand whose tag matches.
    function automatic rs_entry_t rs_wakeup(input rs_entry_t e, input logic bc_valid,
                                            input logic [ROB_IDX_SIZE-1:0] bc_idx,
                                            input logic [GPR_SIZE-1:0] bc_value,
                                            input logic bc_set_nzcv, input nzcv_t bc_nzcv);
        rs_entry_t r;
        r = e;
        if (bc_valid) begin
            if (!r.val_a_valid && r.val_a_tag == bc_idx) begin
                r.val_a       = bc_value;
                r.val_a_valid = 1'b1;
            end
            if (!r.val_b_valid && r.val_b_tag == bc_idx) begin
                r.val_b       = bc_value;
                r.val_b_valid = 1'b1;
            end
            if (bc_set_nzcv && !r.nzcv_valid && r.nzcv_tag == bc_idx) begin
                r.nzcv       = bc_nzcv;
                r.nzcv_valid = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic rs_all_valid(input rs_entry_t e);
        return e.val_a_valid && e.val_b_valid && e.nzcv_valid;
    endfunction

    function automatic issue_t rs_to_issue(input rs_entry_t e);
        issue_t p;
        p.fu_op       = e.fu_op;
        p.val_a       = e.val_a;
        p.val_b       = e.val_b;
        p.nzcv        = e.nzcv;
        p.set_nzcv    = e.set_nzcv;
        p.dst_rob_idx = e.dst_rob_idx;
        return p;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Oldest-ready picker: among ready entries choose the largest age, lowest index on ties.
module rs_select #(
    parameter int unsigned RS_SIZE = 4,
    parameter int unsigned AGE_W   = 3,
    localparam int unsigned IDX_W  = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0] ready_i,
    input  logic [AGE_W-1:0]   age_i [RS_SIZE],
    output logic [IDX_W-1:0]   sel_o,
    output logic               found_o
);

    logic [AGE_W-1:0] best_age;

    // Strict greater-than keeps the lowest index when ages tie.
    always_comb begin
        found_o  = 1'b0;
        sel_o    = '0;
        best_age = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (ready_i[i] && (!found_o || age_i[i] > best_age)) begin
                found_o  = 1'b1;
                sel_o    = IDX_W'(i);
                best_age = age_i[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Per-FU reservation station: buffers dispatched ops, wakes operands from the ROB result
// broadcast, and issues the oldest ready op over a valid/ready handshake.
// Optional macro RS_ISSUE_BYPASS_EN: an all-valid op arriving while nothing is ready and the
// issue register is free goes straight to issue, skipping the entry array.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DFLT,
    parameter fu_t         FU_ID   = FU_ALU,
    parameter int unsigned AGE_W   = 3
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_rob_ready,
    input  logic [1:0]              in_rob_fu_id,
    input  logic [3:0]              in_rob_fu_op,
    input  logic                    in_rob_val_a_valid,
    input  logic                    in_rob_val_b_valid,
    input  logic                    in_rob_nzcv_valid,
    input  logic [GPR_SIZE-1:0]     in_rob_val_a_value,
    input  logic [GPR_SIZE-1:0]     in_rob_val_b_value,
    input  logic [3:0]              in_rob_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_val_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_val_b_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_nzcv_rob_idx,
    input  logic                    in_rob_set_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_dst_rob_idx,
    input  logic                    in_rob_should_broadcast,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_broadcast_index,
    input  logic [GPR_SIZE-1:0]     in_rob_broadcast_value,
    input  logic                    in_rob_broadcast_set_nzcv,
    input  logic [3:0]              in_rob_broadcast_nzcv,
    input  logic                    in_fu_ready,
    output logic                    out_fu_valid,
    output logic [3:0]              out_fu_op,
    output logic [GPR_SIZE-1:0]     out_fu_val_a,
    output logic [GPR_SIZE-1:0]     out_fu_val_b,
    output logic [3:0]              out_fu_nzcv,
    output logic                    out_fu_set_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_idx,
    output logic                    out_rob_stall,
    output logic                    out_overflow
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam logic [AGE_FIELD_W-1:0] AGE_MAX = AGE_FIELD_W'((1 << AGE_W) - 1);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];
    logic      issue_valid_q, issue_valid_d;
    issue_t    issue_q, issue_d;
    logic      overflow_q, overflow_d;

    rs_entry_t        incoming;
    logic [RS_SIZE-1:0] ready;
    logic [AGE_W-1:0] ages [RS_SIZE];
    logic             full, free_found, found, accept, can_load, bypass;
    logic [IDX_W-1:0] free_idx, sel_idx;

    // Readiness, ages and the lowest free slot, all from registered state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready[i] = entries_q[i].busy && rs_all_valid(entries_q[i]);
            ages[i]  = entries_q[i].age[AGE_W-1:0];
            if (!entries_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        full = !free_found;
    end

    rs_select #(
        .RS_SIZE (RS_SIZE),
        .AGE_W   (AGE_W)
    ) u_select (
        .ready_i (ready),
        .age_i   (ages),
        .sel_o   (sel_idx),
        .found_o (found)
    );

    // Incoming op with same-cycle broadcast already folded in.
    always_comb begin
        incoming             = '0;
        incoming.busy        = 1'b1;
        incoming.fu_op       = in_rob_fu_op;
        incoming.val_a       = in_rob_val_a_value;
        incoming.val_a_valid = in_rob_val_a_valid;
        incoming.val_a_tag   = in_rob_val_a_rob_index;
        incoming.val_b       = in_rob_val_b_value;
        incoming.val_b_valid = in_rob_val_b_valid;
        incoming.val_b_tag   = in_rob_val_b_rob_index;
        incoming.nzcv        = in_rob_nzcv;
        incoming.nzcv_valid  = in_rob_nzcv_valid;
        incoming.nzcv_tag    = in_rob_nzcv_rob_idx;
        incoming.set_nzcv    = in_rob_set_nzcv;
        incoming.dst_rob_idx = in_rob_dst_rob_idx;
        incoming = rs_wakeup(incoming, in_rob_should_broadcast, in_rob_broadcast_index,
                             in_rob_broadcast_value, in_rob_broadcast_set_nzcv,
                             in_rob_broadcast_nzcv);
    end

    assign accept   = in_rob_ready && (in_rob_fu_id == FU_ID);
    assign can_load = !issue_valid_q || in_fu_ready;
`ifdef RS_ISSUE_BYPASS_EN
    assign bypass   = accept && can_load && !found && rs_all_valid(incoming);
`else
    assign bypass   = 1'b0;
`endif

    // Entry array next state: wakeup, aging, free on issue, allocate on accept.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                entries_d[i] = rs_wakeup(entries_q[i], in_rob_should_broadcast,
                                         in_rob_broadcast_index, in_rob_broadcast_value,
                                         in_rob_broadcast_set_nzcv, in_rob_broadcast_nzcv);
                if (entries_q[i].age != AGE_MAX) begin
                    entries_d[i].age = entries_q[i].age + 1'b1;
                end
            end
        end
        if (can_load && found) begin
            entries_d[sel_idx].busy = 1'b0;
        end
        if (accept && !bypass && !full) begin
            entries_d[free_idx] = incoming;
        end
        overflow_d = accept && !bypass && full;
    end

    // Issue register: load when empty or firing, otherwise hold the payload.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;
        if (can_load) begin
            if (found) begin
                issue_valid_d = 1'b1;
                issue_d       = rs_to_issue(entries_q[sel_idx]);
            end else if (bypass) begin
                issue_valid_d = 1'b1;
                issue_d       = rs_to_issue(incoming);
            end else begin
                issue_valid_d = 1'b0;
            end
        end
    end

    // State update; reset beats flush, flush beats dispatch and issue.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) entries_q[i] <= '0;
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
            overflow_q    <= 1'b0;
        end else if (in_flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) entries_q[i] <= '0;
            issue_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_fu_valid       = issue_valid_q;
    assign out_fu_op          = issue_q.fu_op;
    assign out_fu_val_a       = issue_q.val_a;
    assign out_fu_val_b       = issue_q.val_b;
    assign out_fu_nzcv        = issue_q.nzcv;
    assign out_fu_set_nzcv    = issue_q.set_nzcv;
    assign out_fu_dst_rob_idx = issue_q.dst_rob_idx;
    assign out_rob_stall      = full;
    assign out_overflow       = overflow_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-level behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RS_N    = 4;
    localparam int AGE_TOP = 7;
`ifdef RS_ISSUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, rob_ready, av, bv, nv, setn, bc_valid, bc_setn, fu_ready;
    logic [1:0]  fu_id;
    logic [3:0]  op, n_in, bc_n;
    logic [63:0] a_in, b_in, bc_value;
    logic [3:0]  at, bt, nt, dst, bc_idx;
    logic        o_valid, o_setn, o_stall, o_ovf;
    logic [3:0]  o_op, o_n, o_dst;
    logic [63:0] o_a, o_b;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(RS_N), .FU_ID(FU_ALU), .AGE_W(3)) dut (
        .in_clk(clk), .in_rst(rst_n), .in_flush(flush), .in_rob_ready(rob_ready),
        .in_rob_fu_id(fu_id), .in_rob_fu_op(op),
        .in_rob_val_a_valid(av), .in_rob_val_b_valid(bv), .in_rob_nzcv_valid(nv),
        .in_rob_val_a_value(a_in), .in_rob_val_b_value(b_in), .in_rob_nzcv(n_in),
        .in_rob_val_a_rob_index(at), .in_rob_val_b_rob_index(bt), .in_rob_nzcv_rob_idx(nt),
        .in_rob_set_nzcv(setn), .in_rob_dst_rob_idx(dst),
        .in_rob_should_broadcast(bc_valid), .in_rob_broadcast_index(bc_idx),
        .in_rob_broadcast_value(bc_value), .in_rob_broadcast_set_nzcv(bc_setn),
        .in_rob_broadcast_nzcv(bc_n), .in_fu_ready(fu_ready),
        .out_fu_valid(o_valid), .out_fu_op(o_op), .out_fu_val_a(o_a), .out_fu_val_b(o_b),
        .out_fu_nzcv(o_n), .out_fu_set_nzcv(o_setn), .out_fu_dst_rob_idx(o_dst),
        .out_rob_stall(o_stall), .out_overflow(o_ovf)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit [3:0]    op;
        bit [63:0]   a, b;
        bit          av, bv, nv;
        int unsigned at, bt, nt;
        bit [3:0]    n;
        bit          setn;
        bit [3:0]    dst;
        int          age;
    } m_op_t;

    m_op_t m_slot [RS_N];
    m_op_t mo;
    m_op_t m_zero;
    bit    mo_valid;
    bit    m_ovf;

    function automatic m_op_t wake(input m_op_t e);
        m_op_t r = e;
        if (bc_valid) begin
            if (!r.av && r.at == int'(bc_idx)) begin r.a = bc_value; r.av = 1; end
            if (!r.bv && r.bt == int'(bc_idx)) begin r.b = bc_value; r.bv = 1; end
            if (bc_setn && !r.nv && r.nt == int'(bc_idx)) begin r.n = bc_n; r.nv = 1; end
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        m_op_t snap [RS_N];
        m_op_t inc;
        int    best, free;
        bit    can, acc, byp;
        if (!rst_n) begin
            for (int i = 0; i < RS_N; i++) m_slot[i] = m_zero;
            mo = m_zero; mo_valid = 0; m_ovf = 0;
        end else if (flush) begin
            for (int i = 0; i < RS_N; i++) m_slot[i].busy = 0;
            mo_valid = 0; m_ovf = 0;
        end else begin
            snap = m_slot;
            best = -1; free = -1;
            for (int i = 0; i < RS_N; i++) begin
                if (snap[i].busy && snap[i].av && snap[i].bv && snap[i].nv &&
                    (best < 0 || snap[i].age > snap[best].age)) best = i;
                if (!snap[i].busy && free < 0) free = i;
            end
            can = !mo_valid || fu_ready;
            for (int i = 0; i < RS_N; i++) if (snap[i].busy) begin
                m_slot[i] = wake(snap[i]);
                m_slot[i].age = (snap[i].age < AGE_TOP) ? snap[i].age + 1 : AGE_TOP;
            end
            inc = m_zero;
            inc.busy = 1; inc.op = op; inc.a = a_in; inc.b = b_in; inc.n = n_in;
            inc.av = av; inc.bv = bv; inc.nv = nv;
            inc.at = at; inc.bt = bt; inc.nt = nt; inc.setn = setn; inc.dst = dst;
            inc = wake(inc);
            acc = rob_ready && fu_id == FU_ALU;
            byp = 0;
`ifdef RS_ISSUE_BYPASS_EN
            byp = acc && can && best < 0 && inc.av && inc.bv && inc.nv;
`endif
            if (can) begin
                if (best >= 0) begin mo = snap[best]; mo_valid = 1; m_slot[best].busy = 0; end
                else if (byp) begin mo = inc; mo_valid = 1; end
                else mo_valid = 0;
            end
            m_ovf = acc && !byp && free < 0;
            if (acc && !byp && free >= 0) m_slot[free] = inc;
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit m_full = 1;
        for (int i = 0; i < RS_N; i++) if (!m_slot[i].busy) m_full = 0;
        cmp("m_valid", o_valid, mo_valid);
        cmp("m_stall", o_stall, m_full);
        cmp("m_overflow", o_ovf, m_ovf);
        if (mo_valid) begin
            cmp("m_op", o_op, mo.op);
            cmp("m_a", o_a, mo.a);
            cmp("m_b", o_b, mo.b);
            cmp("m_nzcv", o_n, mo.n);
            cmp("m_setn", o_setn, mo.setn);
            cmp("m_dst", o_dst, mo.dst);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input logic rdy);
        rst_n = 1; flush = 0; rob_ready = 0; fu_id = FU_ALU; bc_valid = 0; bc_setn = 0;
        fu_ready = rdy;
    endtask

    task automatic disp(input logic [3:0] o, input logic va, input logic [63:0] a,
                        input logic [3:0] ta, input logic vb, input logic [63:0] b,
                        input logic [3:0] tb, input logic vn, input logic [3:0] n,
                        input logic [3:0] tn, input logic sn, input logic [3:0] d);
        rob_ready = 1; fu_id = FU_ALU; op = o;
        av = va; a_in = a; at = ta; bv = vb; b_in = b; bt = tb;
        nv = vn; n_in = n; nt = tn; setn = sn; dst = d;
    endtask

    task automatic bcast(input logic [3:0] idx, input logic [63:0] v);
        bc_valid = 1; bc_idx = idx; bc_value = v; bc_setn = 0; bc_n = 4'h0;
    endtask

    // Bounded wait for issue; n counts edges including the one already taken.
    task automatic wait_issue(output int n);
        n = 1;
        while (!o_valid && n < 6) begin step(); n++; end
    endtask

    int n;

    initial begin
        idle(0);
        op = 0; av = 0; bv = 0; nv = 0; a_in = 0; b_in = 0; n_in = 0; at = 0; bt = 0;
        nt = 0; setn = 0; dst = 0; bc_idx = 0; bc_value = 0; bc_n = 0;
        rst_n = 0;
        step(); step();
        cmp("reset_valid", o_valid, 0);
        cmp("reset_stall", o_stall, 0);
        cmp("reset_overflow", o_ovf, 0);
        cmp("reset_a", o_a, 0);

        // Basic all-valid dispatch.
        idle(1);
        disp(ALU_ADD, 1, 5, 0, 1, 7, 0, 1, 4'h0, 0, 0, 3);
        step(); idle(1);
        wait_issue(n);
        cmp("t1_latency", n, LAT);
        cmp("t1_a", o_a, 5);
        cmp("t1_b", o_b, 7);
        cmp("t1_dst", o_dst, 3);
        step();
        cmp("t1_pulse", o_valid, 0);

        // Operand a waits on tag 2; tag 4 must not wake it.
        disp(ALU_SUB, 0, 0, 2, 1, 1, 0, 1, 4'h0, 0, 0, 5);
        step(); idle(1);
        bcast(4, 64'h99);
        step();
        cmp("t2_nowake", o_valid, 0);
        idle(1); bcast(2, 64'h55);
        step(); idle(1);
        wait_issue(n);
        cmp("t2_latency", n, 2);
        cmp("t2_a", o_a, 64'h55);
        step();

        // Same-cycle broadcast and dispatch.
        disp(ALU_AND, 0, 0, 6, 1, 2, 0, 1, 4'h0, 0, 0, 7);
        bcast(6, 64'd9);
        step(); idle(1);
        wait_issue(n);
        cmp("t3_latency", n, LAT);
        cmp("t3_a", o_a, 9);
        step();

        // Fill with the FU stalled, then overflow.
        idle(0);
        for (int k = 0; k < 5; k++) begin
            disp(ALU_ADD, 1, 64'(10 + k), 0, 1, 0, 0, 1, 4'h0, 0, 0, 4'(k));
            step();
        end
        cmp("t4_stall", o_stall, 1);
        disp(ALU_ADD, 1, 99, 0, 1, 0, 0, 1, 4'h0, 0, 0, 9);
        step();
        cmp("t4_overflow", o_ovf, 1);
        cmp("t4_held_a", o_a, 10);
        idle(0);
        step();
        cmp("t4_ovf_pulse", o_ovf, 0);
        cmp("t4_still_a", o_a, 10);
        idle(1);
        repeat (8) step();

        // Older entry sits at a higher index and must issue first.
        idle(0);
        disp(ALU_ADD, 1, 100, 0, 1, 0, 0, 1, 4'h0, 0, 0, 1); step();
        disp(ALU_ADD, 1, 200, 0, 1, 0, 0, 1, 4'h0, 0, 0, 2); step();
        disp(ALU_ADD, 1, 300, 0, 1, 0, 0, 1, 4'h0, 0, 0, 3); step();
        idle(1);
        step();
        cmp("t5_first", o_a, 200);
        step();
        cmp("t5_second", o_a, 300);
        step();
        cmp("t5_drain", o_valid, 0);

        // Flush clears queue and issue register.
        idle(0);
        disp(ALU_ADD, 1, 1, 0, 1, 0, 0, 1, 4'h0, 0, 0, 1); step();
        disp(ALU_ADD, 1, 2, 0, 1, 0, 0, 1, 4'h0, 0, 0, 2); step();
        disp(ALU_ADD, 1, 3, 0, 1, 0, 0, 1, 4'h0, 0, 0, 3); flush = 1; step();
        cmp("t5_flush_valid", o_valid, 0);
        cmp("t5_flush_stall", o_stall, 0);

        // Reset mid-issue, then one more dispatch.
        idle(0);
        for (int k = 0; k < 3; k++) begin
            disp(ALU_ORR, 1, 64'(40 + k), 0, 1, 0, 0, 1, 4'h0, 0, 0, 4'(k)); step();
        end
        idle(0); rst_n = 0;
        step();
        cmp("t6_valid", o_valid, 0);
        cmp("t6_stall", o_stall, 0);
        cmp("t6_a", o_a, 0);
        cmp("t6_dst", o_dst, 0);
        idle(1);
        disp(ALU_ADD, 1, 77, 0, 1, 0, 0, 1, 4'h0, 0, 0, 6);
        step(); idle(1);
        wait_issue(n);
        cmp("t6_latency", n, LAT);
        cmp("t6_a2", o_a, 77);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rob_ready = 1'($urandom_range(0, 1));
            fu_id     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : FU_ALU;
            op        = 4'($urandom_range(0, 15));
            av        = ($urandom_range(0, 9) < 6);
            bv        = ($urandom_range(0, 9) < 6);
            nv        = ($urandom_range(0, 9) < 7);
            a_in      = {$urandom, $urandom};
            b_in      = {$urandom, $urandom};
            n_in      = 4'($urandom_range(0, 15));
            at        = 4'($urandom_range(0, 7));
            bt        = 4'($urandom_range(0, 7));
            nt        = 4'($urandom_range(0, 7));
            setn      = 1'($urandom_range(0, 1));
            dst       = 4'($urandom_range(0, 15));
            bc_valid  = ($urandom_range(0, 9) < 4);
            bc_idx    = 4'($urandom_range(0, 7));
            bc_value  = {$urandom, $urandom};
            bc_setn   = 1'($urandom_range(0, 1));
            bc_n      = 4'($urandom_range(0, 15));
            fu_ready  = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
Per-FU reservation station sitting directly downstream of the ROB. It accepts dispatched micro-ops (fu_op, operands or ROB tags, dst ROB index) from the ROB's RS outputs and snoops the ROB result broadcast to wake waiting operands. It issues the oldest fully-ready entry to its functional unit over a valid/ready handshake. One instance exists per FU; it accepts only ops whose fu_id equals FU_ID.

Parameters:
RS_SIZE, 4, number of entries (power of two, >=2)
FU_ID, FU_ALU, fu_t value this instance accepts
AGE_W, 3, width of the saturating per-entry age counter

Ports:
in_clk  in  1  clock, all state on posedge
in_rst  in  1  synchronous reset, active-low
in_flush  in  1  mispredict flush; clears all entries
in_rob_ready  in  1  dispatch valid from ROB
in_rob_fu_id  in  fu_t  target FU of the dispatched op
in_rob_fu_op  in  alu_op_t  operation
in_rob_val_a_valid / in_rob_val_b_valid / in_rob_nzcv_valid  in  1 each  operand present
in_rob_val_a_value / in_rob_val_b_value  in  GPR_SIZE each  operand values
in_rob_nzcv  in  nzcv_t  flags value
in_rob_val_a_rob_index / in_rob_val_b_rob_index / in_rob_nzcv_rob_idx  in  ROB_IDX_SIZE each  producer tags
in_rob_set_nzcv  in  1  op writes flags
in_rob_dst_rob_idx  in  ROB_IDX_SIZE  destination ROB slot
in_rob_should_broadcast  in  1  result broadcast valid
in_rob_broadcast_index  in  ROB_IDX_SIZE  broadcast tag
in_rob_broadcast_value  in  GPR_SIZE  broadcast value
in_rob_broadcast_set_nzcv  in  1  broadcast carries flags
in_rob_broadcast_nzcv  in  nzcv_t  broadcast flags
in_fu_ready  in  1  FU accepts the issue this cycle
out_fu_valid  out  1  issue valid
out_fu_op  out  alu_op_t  issued op
out_fu_val_a / out_fu_val_b  out  GPR_SIZE each  issued operands
out_fu_nzcv  out  nzcv_t  issued flags
out_fu_set_nzcv  out  1  issued op writes flags
out_fu_dst_rob_idx  out  ROB_IDX_SIZE  issued destination
out_rob_stall  out  1  no free entry
out_overflow  out  1  one-cycle pulse: dispatch dropped while full

Behaviour:
- Reset (in_rst==0 at posedge): all entries invalid, ages 0; all outputs 0 except out_rob_stall=0.
- Accept: in_rob_ready && in_rob_fu_id==FU_ID. Allocates the lowest-index free entry with age=0. Other fu_ids are ignored.
- Full: out_rob_stall=1 when every entry is busy. It is computed from registered state, so a slot freed this cycle is reusable next cycle.
- Accept while full: the op is dropped and out_overflow pulses for one cycle.
- Wakeup: each cycle with in_rob_should_broadcast, every busy entry's invalid operand whose tag == in_rob_broadcast_index captures the broadcast value and is marked valid.
  - The nzcv operand captures in_rob_broadcast_nzcv only if in_rob_broadcast_set_nzcv=1.
  - Same-cycle broadcast and dispatch: the incoming op's tags are also compared, so the allocated entry stores the captured value.
- Ready: busy entry with val_a, val_b and nzcv all valid.
- Age: every busy entry's age increments each cycle, saturating at 2^AGE_W-1.
- Select: the ready entry with the largest age; ties go to the lowest index.
- Issue register: loads the selected entry when out_fu_valid==0 or (out_fu_valid && in_fu_ready). The source entry is freed on the same edge.
  - Payload is held stable while out_fu_valid && !in_fu_ready.
  - out_fu_valid drops after a fire if nothing is selected.
- Latency: dispatch of an all-valid op at edge N gives out_fu_valid=1 after edge N+1 (2 cycles). A broadcast wakeup at edge N gives issue after edge N+1.
- Flush: in_flush=1 clears all entries and out_fu_valid on the next edge, and has priority over same-cycle dispatch and issue. Reset has priority over flush.
- Entries already in the issue register are not affected by broadcasts.

Optional Feature:
RS_ISSUE_BYPASS_EN
- Defined: when no entry is ready and the issue register is free or firing, an accepted op that is all-valid (after same-cycle broadcast capture) loads directly into the issue register without allocating an entry. Latency is 1 cycle.
- Undefined: every op goes through the entry array. Latency is 2 cycles.

Decomposition:
- data_structures package: rs_entry_t struct (busy, fu_op, val_a/val_b/nzcv value+valid+tag, set_nzcv, dst_rob_idx, age) and an RS_SIZE default macro.
- One sub-module, rs_select: combinational oldest-ready picker over RS_SIZE ready bits and ages. Outputs a select index and a found flag.

Test Plan:
- Dispatch ADD a=5, b=7, nzcv valid, dst=3; in_fu_ready=1 -> out_fu_valid after 2 edges, val_a=5, val_b=7, dst=3; single-cycle pulse.
- Dispatch with a waiting on tag 2, then broadcast idx=2, value=0x55 -> issue one edge after the broadcast with val_a=0x55; a broadcast on tag 4 causes no wake.
- Dispatch with a waiting on tag 6 in the same cycle as broadcast idx=6, value=9 -> entry captures 9 and issues 2 edges later.
- Fill 4 entries, hold in_fu_ready=0 -> out_rob_stall=1; a 5th dispatch pulses out_overflow; issue payload stays stable until ready.
- Two ready entries, the older allocated first -> older issues first; then in_flush -> out_fu_valid=0, out_rob_stall=0 next cycle.
- Assert in_rst=0 mid-issue with pending entries -> all outputs 0 after the edge; with RS_ISSUE_BYPASS_EN, an all-valid op issues after 1 edge.
